// File: rtl/sample_capture_dma.sv
`default_nettype none
// ============================================================================
// sample_capture_dma : sign-extends a sample stream and DMA-writes it to SDRAM
//   for the sorter. Optional macro: CAPTURE_OFFSET_BINARY_EN.  Rev 1.0
// ============================================================================
module sample_capture_dma #(
  parameter int          DATA_W       = 24,
  parameter int          MAX_COUNT    = 1024,
  parameter logic [31:0] DEFAULT_BASE = 32'h6000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              slave_waitrequest,
  input  logic [1:0]        slave_address,
  input  logic              slave_read,
  output logic [31:0]       slave_readdata,
  input  logic              slave_write,
  input  logic [31:0]       slave_writedata,
  input  logic              master_waitrequest,
  output logic [31:0]       master_address,
  output logic              master_write,
  output logic [31:0]       master_writedata,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              sort_start
);

  localparam int                 c_CNT_W     = $clog2(MAX_COUNT + 1);
  localparam logic [c_CNT_W-1:0] c_MAX_CNT   = c_CNT_W'(MAX_COUNT);
  localparam logic [c_CNT_W-1:0] c_ONE       = c_CNT_W'(1);
  localparam logic [31:0]        c_MAX_CNT32 = 32'(MAX_COUNT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t               r_state;
  logic [31:0]          r_base;
  logic [c_CNT_W-1:0]   r_count;
  logic [c_CNT_W-1:0]   r_words;

  logic                 w_busy;
  logic                 w_done;
  logic                 w_wr_ok;
  logic                 w_start;
  logic [c_CNT_W-1:0]   w_words_next;
  logic [31:0]          w_word_addr;
  logic [31:0]          w_sample_ext;
  logic [31:0]          w_sample_conv;

  assign w_busy            = (r_state == S_CAPTURE) || (r_state == S_WRITE);
  assign w_done            = (r_state == S_DONE);
  // Slave writes are parked while a run is in flight, then land once DONE.
  assign slave_waitrequest = slave_write && w_busy;
  assign w_wr_ok           = slave_write && !w_busy;
  assign w_start           = w_wr_ok && (slave_address == 2'd0);
  assign w_words_next      = r_words + c_ONE;
  assign w_word_addr       = r_base + {{(30 - c_CNT_W){1'b0}}, r_words, 2'b00};

  generate
    if (DATA_W == 32) begin : g_full_width
      assign w_sample_ext = in_data;
    end else begin : g_sign_extend
      assign w_sample_ext = {{(32 - DATA_W){in_data[DATA_W-1]}}, in_data};
    end
  endgenerate

`ifdef CAPTURE_OFFSET_BINARY_EN
  // Flip the sign bit so an unsigned compare orders samples by signed value.
  assign w_sample_conv = {~w_sample_ext[31], w_sample_ext[30:0]};
`else
  assign w_sample_conv = w_sample_ext;
`endif

  always_comb begin
    slave_readdata = 32'd0;
    if (slave_read) begin
      case (slave_address)
        2'd0:    slave_readdata = {30'd0, w_done, w_busy};
        2'd1:    slave_readdata = r_base;
        2'd2:    slave_readdata = {{(32 - c_CNT_W){1'b0}}, r_count};
        default: slave_readdata = {{(32 - c_CNT_W){1'b0}}, r_words};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_base           <= DEFAULT_BASE;
      r_count          <= c_MAX_CNT;
      r_words          <= '0;
      in_ready         <= 1'b0;
      master_write     <= 1'b0;
      master_address   <= 32'd0;
      master_writedata <= 32'd0;
      sort_start       <= 1'b0;
    end else begin
      sort_start <= 1'b0;

      if (w_wr_ok && (slave_address == 2'd1)) begin
        r_base <= {slave_writedata[31:2], 2'b00};
      end
      if (w_wr_ok && (slave_address == 2'd2)) begin
        r_count <= (slave_writedata > c_MAX_CNT32) ? c_MAX_CNT
                                                   : slave_writedata[c_CNT_W-1:0];
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_words <= '0;
            if (r_count != '0) begin
              r_state  <= S_CAPTURE;
              in_ready <= 1'b1;
            end else begin
              r_state    <= S_DONE;
              sort_start <= 1'b1;
            end
          end
        end

        S_CAPTURE: begin
          if (in_valid) begin
            in_ready         <= 1'b0;
            master_write     <= 1'b1;
            master_address   <= w_word_addr;
            master_writedata <= w_sample_conv;
            r_state          <= S_WRITE;
          end
        end

        S_WRITE: begin
          if (!master_waitrequest) begin
            master_write <= 1'b0;
            r_words      <= w_words_next;
            if (w_words_next == r_count) begin
              r_state    <= S_DONE;
              sort_start <= 1'b1;
            end else begin
              r_state  <= S_CAPTURE;
              in_ready <= 1'b1;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sample_capture_dma.sv
`default_nettype none
`timescale 1ns/1ps
// Directed bench for sample_capture_dma; a negedge monitor scores every SDRAM write.
module tb_sample_capture_dma;

  localparam int DATA_W = 24;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              slave_waitrequest;
  logic [1:0]        slave_address;
  logic              slave_read;
  logic [31:0]       slave_readdata;
  logic              slave_write;
  logic [31:0]       slave_writedata;
  logic              master_waitrequest;
  logic [31:0]       master_address;
  logic              master_write;
  logic [31:0]       master_writedata;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              sort_start;

  int total    = 0;
  int bad      = 0;
  int sort_cnt = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];

  always #5 clk = ~clk;

  sample_capture_dma #(
    .DATA_W       (DATA_W),
    .MAX_COUNT    (1024),
    .DEFAULT_BASE (32'h6000)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .slave_waitrequest  (slave_waitrequest),
    .slave_address      (slave_address),
    .slave_read         (slave_read),
    .slave_readdata     (slave_readdata),
    .slave_write        (slave_write),
    .slave_writedata    (slave_writedata),
    .master_waitrequest (master_waitrequest),
    .master_address     (master_address),
    .master_write       (master_write),
    .master_writedata   (master_writedata),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_data            (in_data),
    .sort_start         (sort_start)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cv(input logic [31:0] ext);
`ifdef CAPTURE_OFFSET_BINARY_EN
    return ext ^ 32'h8000_0000;
`else
    return ext;
`endif
  endfunction

  // Scoreboard monitor: each accepted SDRAM write must match the oldest expectation.
  always @(negedge clk) begin
    wr_t e;
    if (sort_start) sort_cnt++;
    if (rst_n && master_write && !master_waitrequest) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr=0x%08h data=0x%08h expected no write",
                 master_address, master_writedata);
      end else begin
        e = sb.pop_front();
        check("wr_addr", master_address, e.addr);
        check("wr_data", master_writedata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    slave_address = a;
    slave_read    = 1'b1;
    #1;
    check(name, slave_readdata, exp);
    slave_read = 1'b0;
  endtask

  task automatic swr(input logic [1:0] a, input logic [31:0] d);
    bit ok = 1'b0;
    slave_address   = a;
    slave_writedata = d;
    slave_write     = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (!slave_waitrequest) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    slave_write = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL slave_write_timeout: got waitrequest=1 expected 0");
    end
  endtask

  task automatic feed(input logic [DATA_W-1:0] d, input logic [31:0] addr, input logic [31:0] ext);
    bit  ok = 1'b0;
    wr_t e;
    e.addr = addr;
    e.data = cv(ext);
    sb.push_back(e);
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL sample_accept_timeout: got in_ready=0 expected 1");
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n              = 1'b0;
    slave_address      = 2'd0;
    slave_read         = 1'b0;
    slave_write        = 1'b0;
    slave_writedata    = 32'd0;
    master_waitrequest = 1'b0;
    in_valid           = 1'b0;
    in_data            = '0;

    // Reset state
    #2;
    check("rst_slave_waitrequest", {31'd0, slave_waitrequest}, 32'd0);
    check("rst_slave_readdata", slave_readdata, 32'd0);
    check("rst_master_address", master_address, 32'd0);
    check("rst_master_write", {31'd0, master_write}, 32'd0);
    check("rst_master_writedata", master_writedata, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_sort_start", {31'd0, sort_start}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    rd(2'd0, 32'd0, "rst_status");
    rd(2'd1, 32'h6000, "rst_base");
    rd(2'd2, 32'd1024, "rst_count");
    rd(2'd3, 32'd0, "rst_words");

    // Basic four-word run
    swr(2'd2, 32'd4);
    swr(2'd0, 32'd0);
    feed(24'd3, 32'h6000, 32'd3);
    feed(24'd1, 32'h6004, 32'd1);
    feed(24'd2, 32'h6008, 32'd2);
    feed(24'd0, 32'h600C, 32'd0);
    repeat (4) tick();
    check("run1_sort_pulses", 32'(sort_cnt), 32'd1);
    rd(2'd0, 32'd2, "run1_status_done");
    rd(2'd3, 32'd4, "run1_words");
    check("run1_sb_empty", 32'(sb.size()), 32'd0);

    // Restart from DONE, stall the second write for three clocks
    swr(2'd0, 32'd0);
    rd(2'd0, 32'd1, "run2_status_busy");
    rd(2'd3, 32'd0, "run2_words_cleared");
    feed(24'd5, 32'h6000, 32'd5);
    tick();
    master_waitrequest = 1'b1;
    feed(24'h800000, 32'h6004, 32'hFF80_0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_master_write", {31'd0, master_write}, 32'd1);
      check("stall_address", master_address, 32'h6004);
      check("stall_data", master_writedata, cv(32'hFF80_0000));
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    rd(2'd3, 32'd1, "stall_words");
    @(posedge clk);
    #1;
    master_waitrequest = 1'b0;
    tick();
    rd(2'd3, 32'd2, "release_words");
    feed(24'hFFFFFF, 32'h6008, 32'hFFFF_FFFF);
    feed(24'h000001, 32'h600C, 32'h0000_0001);
    repeat (4) tick();
    check("run2_sort_pulses", 32'(sort_cnt), 32'd2);
    rd(2'd3, 32'd4, "run2_words");

    // COUNT of zero and clamping, with simultaneous read/write
    swr(2'd2, 32'd0);
    rd(2'd2, 32'd0, "count_zero");
    swr(2'd0, 32'd0);
    check("count0_sort_start", {31'd0, sort_start}, 32'd1);
    rd(2'd0, 32'd2, "count0_status_done");
    tick();
    tick();
    check("count0_sort_pulses", 32'(sort_cnt), 32'd3);
    check("count0_no_write", {31'd0, master_write}, 32'd0);
    slave_address   = 2'd2;
    slave_writedata = 32'd5000;
    slave_write     = 1'b1;
    slave_read      = 1'b1;
    #1;
    check("rw_same_cycle_old_value", slave_readdata, 32'd0);
    @(posedge clk);
    #1;
    slave_write = 1'b0;
    slave_read  = 1'b0;
    rd(2'd2, 32'd1024, "count_clamped");

    // BASE write while busy is held until DONE
    swr(2'd2, 32'd1);
    swr(2'd0, 32'd0);
    fork
      swr(2'd1, 32'h0000_1237);
      begin
        repeat (2) begin
          @(negedge clk);
          check("busy_waitrequest", {31'd0, slave_waitrequest}, 32'd1);
        end
        @(posedge clk);
        #1;
        feed(24'h7FFFFF, 32'h6000, 32'h007F_FFFF);
      end
    join
    rd(2'd1, 32'h1234, "base_applied_after_done");
    check("run3_sort_pulses", 32'(sort_cnt), 32'd4);
    check("run3_sb_empty", 32'(sb.size()), 32'd0);

    // Reset during a stalled write
    swr(2'd2, 32'd2);
    swr(2'd0, 32'd0);
    master_waitrequest = 1'b1;
    feed(24'h000010, 32'h1234, 32'h0000_0010);
    check("pre_rst_master_write", {31'd0, master_write}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_master_write", {31'd0, master_write}, 32'd0);
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    rd(2'd0, 32'd0, "rst_mid_status");
    sb.delete();
    master_waitrequest = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    rd(2'd1, 32'h6000, "post_rst_base");
    rd(2'd2, 32'd1024, "post_rst_count");
    rd(2'd3, 32'd0, "post_rst_words");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
